// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side pointer, full/almost-full, level and sticky overflow logic of an async FIFO.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH = 4,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  input  logic                  woverflow_clr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wen,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_THRESH = (ADDR_WIDTH+1)'(DEPTH - ALMOST_FULL_MARGIN);
  logic [ADDR_WIDTH:0] wbin_q, wbin_d, wptr_q, wptr_d, wlevel_q, wlevel_d, rbin;
  logic wfull_q, wfull_d, walmost_full_q, walmost_full_d, woverflow_q, woverflow_d;
  always_comb begin
    wen = winc && !wfull_q && !rst;
    wbin_d = wbin_q + {{ADDR_WIDTH{1'b0}}, wen};
    wptr_d = wbin_d ^ (wbin_d >> 1);
    for (int i = 0; i <= ADDR_WIDTH; i++) rbin[i] = ^(wq2_rptr >> i);
    wlevel_d = wbin_d - rbin;
    // full when the pointers differ only in the top two Gray bits
    wfull_d = wptr_d == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
    walmost_full_d = wlevel_d >= AF_THRESH;
    woverflow_d = (winc && wfull_q) || (woverflow_q && !woverflow_clr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q <= '0;
      wptr_q <= '0;
      wlevel_q <= '0;
      wfull_q <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q <= 1'b0;
    end else begin
      wbin_q <= wbin_d;
      wptr_q <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q <= woverflow_d;
    end
  end
  assign waddr = wbin_q[ADDR_WIDTH-1:0];
  assign wptr = wptr_q;
  assign wfull = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel = wlevel_q;
  assign woverflow = woverflow_q;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: table vectors plus scoreboard of a level-based model for the write-side FIFO logic.
module tb_fifo_wptr_full;
  logic clk = 0, rst = 0, winc = 0, woverflow_clr = 0;
  logic [4:0] wq2_rptr = '0;
  logic [3:0] waddr;
  logic [4:0] wptr, wlevel;
  logic wen, wfull, walmost_full, woverflow;
  int checks = 0, errors = 0;
  int m_bin = 0;
  bit m_full = 0, m_ovf = 0;
  typedef struct {logic [3:0] waddr; logic [4:0] wptr; logic full; logic af; logic [4:0] level; logic ovf;} exp_t;
  exp_t q[$];
  typedef struct {logic w; int rb; logic [4:0] lvl; logic full; logic af;} vec_t;
  vec_t vecs[16];

  fifo_wptr_full dut (
    .clk(clk), .rst(rst), .winc(winc), .wq2_rptr(wq2_rptr), .woverflow_clr(woverflow_clr),
    .waddr(waddr), .wptr(wptr), .wen(wen), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .woverflow(woverflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input int rb, input logic c, input logic r);
    exp_t e;
    int lvl;
    bit acc;
    winc = w; woverflow_clr = c; rst = r;
    wq2_rptr = 5'(rb ^ (rb >> 1));
    acc = !r && w && !m_full;
    #1 chk("wen", int'(wen), int'(acc));
    if (r) begin
      m_bin = 0; m_full = 0; m_ovf = 0; lvl = 0;
    end else begin
      m_ovf = (w && m_full) || (m_ovf && !c);
      m_bin = (m_bin + int'(acc)) % 32;
      lvl = (m_bin - rb + 32) % 32;
      m_full = (lvl == 16);
    end
    e.waddr = 4'(m_bin % 16);
    e.wptr = 5'(m_bin ^ (m_bin >> 1));
    e.full = m_full;
    e.af = !r && lvl >= 14;
    e.level = 5'(lvl);
    e.ovf = m_ovf;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("waddr", int'(waddr), int'(e.waddr));
    chk("wptr", int'(wptr), int'(e.wptr));
    chk("wfull", int'(wfull), int'(e.full));
    chk("walmost_full", int'(walmost_full), int'(e.af));
    chk("wlevel", int'(wlevel), int'(e.level));
    chk("woverflow", int'(woverflow), int'(e.ovf));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i].w = 1; vecs[i].rb = 0;
      vecs[i].lvl = 5'(i + 1);
      vecs[i].full = (i == 15);
      vecs[i].af = (i >= 13);
    end
    @(posedge clk); #1;
    cyc(1, 0, 1, 1);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].w, vecs[i].rb, 0, 0);
      chk("tbl_level", int'(wlevel), int'(vecs[i].lvl));
      chk("tbl_full", int'(wfull), int'(vecs[i].full));
      chk("tbl_af", int'(walmost_full), int'(vecs[i].af));
    end
    chk("full_wptr", int'(wptr), 24);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    chk("ovf_set", int'(woverflow), 1);
    cyc(0, 0, 1, 0);
    chk("ovf_clr", int'(woverflow), 0);
    cyc(1, 0, 1, 0);
    chk("ovf_set_wins", int'(woverflow), 1);
    cyc(0, 1, 0, 0);
    chk("read_level", int'(wlevel), 15);
    chk("read_notfull", int'(wfull), 0);
    cyc(1, 1, 0, 0);
    chk("refill_full", int'(wfull), 1);
    cyc(0, 0, 0, 1);
    for (int k = 0; k < 40; k++) begin
      logic [4:0] prev;
      prev = wptr;
      cyc(1, (k < 2 ? 0 : k - 2) % 32, 0, 0);
      chk("hamming", $countones(wptr ^ prev), 1);
    end
    chk("wrap_waddr", int'(waddr), 8);
    cyc(0, 0, 0, 1);
    for (int k = 0; k < 9; k++) cyc(1, 0, 0, 0);
    chk("pre_rst_level", int'(wlevel), 9);
    cyc(1, 0, 0, 1);
    chk("rst_all", int'({waddr, wptr, wfull, walmost_full, wlevel, woverflow}), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wptr_full.md
FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Interface
Parameters:
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, the FIFO address width; DEPTH = 2**ADDR_WIDTH.
REQ-002 The block SHALL have parameter ALMOST_FULL_MARGIN, default 2, the number of free entries at or below which walmost_full asserts; legal range 1..DEPTH-1.

Ports:
REQ-003 The block SHALL have port clk, input, 1, write-domain clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 The block SHALL have port winc, input, 1, write request for the current cycle.
REQ-006 The block SHALL have port wq2_rptr, input, ADDR_WIDTH+1, Gray-coded read pointer from the write-domain 2-FF synchronizer.
REQ-007 The block SHALL have port woverflow_clr, input, 1, clears the sticky overflow flag.
REQ-008 The block SHALL have port waddr, output, ADDR_WIDTH, RAM write address.
REQ-009 The block SHALL have port wptr, output, ADDR_WIDTH+1, registered Gray-coded write pointer; it feeds the read-domain synchronizer.
REQ-010 The block SHALL have port wen, output, 1, RAM write enable, combinational: winc && !wfull.
REQ-011 The block SHALL have port wfull, output, 1, registered full flag.
REQ-012 The block SHALL have port walmost_full, output, 1, registered almost-full flag.
REQ-013 The block SHALL have port wlevel, output, ADDR_WIDTH+1, registered fill level, range 0..DEPTH.
REQ-014 The block SHALL have port woverflow, output, 1, sticky flag set by a write attempted while full.

Function
REQ-015 The block SHALL hold an internal binary pointer wbin of ADDR_WIDTH+1 bits; waddr SHALL equal wbin[ADDR_WIDTH-1:0].
REQ-016 A write SHALL be accepted in a cycle exactly when wen=1; then wbin_next = wbin+1 (mod 2**(ADDR_WIDTH+1)); otherwise wbin_next = wbin.
REQ-017 wptr SHALL register gray(wbin_next) = wbin_next ^ (wbin_next>>1), so wptr always equals gray(wbin) and changes by exactly one bit per accepted write.
REQ-018 wfull SHALL register (gray(wbin_next) == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]}).
REQ-019 With wfull=1 and winc=1: no write, wbin/wptr/waddr unchanged, wen=0.
REQ-020 wlevel SHALL register (wbin_next - gray2bin(wq2_rptr)) mod 2**(ADDR_WIDTH+1); gray2bin bit i = XOR of wq2_rptr bits ADDR_WIDTH..i.
REQ-021 walmost_full SHALL register (level_next >= DEPTH - ALMOST_FULL_MARGIN), where level_next is the value registered into wlevel.
REQ-022 wfull=1 SHALL coincide with wlevel=DEPTH; both SHALL use the same wbin_next and wq2_rptr sample.
REQ-023 The level and flags SHALL be pessimistic: a read-pointer advance lowers wlevel and wfull only after it reaches wq2_rptr, and takes effect one cycle after that.
REQ-024 woverflow SHALL be set the cycle after winc=1 while wfull=1.
REQ-025 woverflow SHALL be cleared the cycle after woverflow_clr=1 and SHALL otherwise hold its value.
REQ-026 If woverflow_clr and an overflow attempt occur in the same cycle, set SHALL win and woverflow SHALL be 1.
REQ-027 Pointer wrap SHALL be natural: wbin wraps from 2**(ADDR_WIDTH+1)-1 to 0 and waddr wraps from DEPTH-1 to 0, with no special case.

Reset
REQ-028 When rst=1 at a clk edge, the block SHALL set wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0 and woverflow=0; waddr SHALL therefore be 0.
REQ-029 rst SHALL take priority over winc and woverflow_clr in the same cycle.
REQ-030 While rst=1, wen SHALL be 0.
REQ-031 A reset mid-operation SHALL discard all state; the read domain is reset by the system at the same time.

Verification
REQ-032 Reset, then hold wq2_rptr=0 and winc=1 for 16 cycles -> waddr goes 0..15, wptr goes through gray 0..15, wfull=1 after the 16th write with wptr=5'b11000 and wlevel=16.
REQ-033 Writes 14 and 15 with wq2_rptr=0 -> walmost_full=1 from wlevel=14, and wfull=0 until wlevel=16.
REQ-034 Hold winc=1 while full for 3 cycles -> wptr and waddr unchanged, wen=0, woverflow=1.
REQ-035 Pulse woverflow_clr -> woverflow=0; assert woverflow_clr together with an overflow attempt -> woverflow stays 1.
REQ-036 While full, set wq2_rptr=gray(1)=5'b00001 -> wfull=0 and wlevel=15 one cycle later; one more write -> wfull=1.
REQ-037 Run 40 writes with a read model that keeps wq2_rptr 2 writes behind -> wbin wraps through 31->0, every wptr step has Hamming distance 1, and wlevel matches the model.
REQ-038 Assert rst while wlevel=9 and winc=1 -> all outputs 0 the next cycle.
